// File: rtl/rtc_bus_pkg.sv
// Shared types and bus idle levels for the RTC bus sequencer and its init table.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_STB,
    S_ADDR_GAP,
    S_DATA_STB,
    S_DATA_GAP,
    S_DONE
  } state_t;

  localparam int ENTRY_W = 8;

  typedef struct packed {
    logic [ENTRY_W-1:0] addr;
    logic [ENTRY_W-1:0] data;
  } entry_t;

  // Levels driven onto the bus whenever no transfer is in progress
  localparam logic STB_IDLE    = 1'b1;
  localparam logic OE_IDLE     = 1'b0;
  localparam logic AD_SEL_IDLE = 1'b0;

endpackage

// File: rtl/rtc_init_table.sv
// Combinational index -> {addr, data} lookup of the RTC init sequence.
// Entry 3 selects the 12/24 h format; indices past 15 read as 00/00.
module rtc_init_table
  import rtc_bus_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             mode_24h,
  output entry_t           entry
);

  int i;

  always_comb begin
    i     = int'(idx);
    entry = '0;
    case (i)
      0:  entry = {8'h02, 8'h10};
      1:  entry = {8'h02, 8'h00};
      2:  entry = {8'h10, 8'hD2};
      3:  entry = {8'h00, (mode_24h ? 8'h0A : 8'h1A)};
      4:  entry = {8'h21, 8'h00};
      5:  entry = {8'h22, 8'h00};
      6:  entry = {8'h23, 8'h03};
      7:  entry = {8'h24, 8'h26};
      8:  entry = {8'h25, 8'h04};
      9:  entry = {8'h26, 8'h16};
      10: entry = {8'h43, 8'h23};
      11: entry = {8'h42, 8'h58};
      12: entry = {8'h41, 8'h59};
      13: entry = {8'hF2, 8'hF2};
      14: entry = {8'h01, 8'h00};
      15: entry = {8'hF1, 8'hF1};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Drives the RTC init table over a multiplexed address/data write bus, one strobe+gap per phase.
// Optional abort_i/aborted_o ports are built in when RTC_SEQ_ABORT_EN is defined.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_ENTRIES = 16,
  parameter int T_STROBE  = 7,
  parameter int T_GAP     = 7
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              start_i,
  input  logic              mode_24h_i,
  output logic [DATA_W-1:0] ad_o,
  output logic              ad_oe_o,
  output logic              a_d_o,
  output logic              rd_n_o,
  output logic              wr_n_o,
  output logic              cs_n_o,
  output logic              busy_o,
`ifdef RTC_SEQ_ABORT_EN
  input  logic              abort_i,
  output logic              aborted_o,
`endif
  output logic              done_o
);

  localparam int T_MAX = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(T_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENTRIES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mode_q, mode_d;
  entry_t            entry;
  logic              abort_req;

  logic [DATA_W-1:0] ad_d;
  logic              oe_d, a_d_d, cs_d, wr_d, busy_d, done_d;

`ifdef RTC_SEQ_ABORT_EN
  logic aborted_d;
  assign abort_req = abort_i;
`else
  assign abort_req = 1'b0;
`endif

  // Looked up with the next index so the registered bus value lines up with the state it belongs to
  rtc_init_table #(.IDX_W(IDX_W)) u_table (
    .idx      (idx_d),
    .mode_24h (mode_d),
    .entry    (entry)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ADDR_STB;
          cnt_d   = '0;
          idx_d   = '0;
          mode_d  = mode_24h_i;
        end
      end
      S_ADDR_STB: begin
        if (cnt_q == STB_LAST) begin
          state_d = S_ADDR_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ADDR_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_DATA_STB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA_STB: begin
        if (cnt_q == STB_LAST) begin
          state_d = S_DATA_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR_STB;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_req && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end

`ifdef RTC_SEQ_ABORT_EN
    aborted_d = abort_req && (state_q != S_IDLE);
`endif

    ad_d   = '0;
    oe_d   = OE_IDLE;
    a_d_d  = AD_SEL_IDLE;
    cs_d   = STB_IDLE;
    wr_d   = STB_IDLE;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      S_ADDR_STB: begin
        ad_d = DATA_W'(entry.addr);
        oe_d = 1'b1;
        cs_d = 1'b0;
        wr_d = 1'b0;
      end
      S_ADDR_GAP: begin
        ad_d = DATA_W'(entry.addr);
        oe_d = 1'b1;
      end
      S_DATA_STB: begin
        ad_d  = DATA_W'(entry.data);
        oe_d  = 1'b1;
        a_d_d = 1'b1;
        cs_d  = 1'b0;
        wr_d  = 1'b0;
      end
      S_DATA_GAP: begin
        ad_d  = DATA_W'(entry.data);
        oe_d  = 1'b1;
        a_d_d = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      ad_o    <= '0;
      ad_oe_o <= OE_IDLE;
      a_d_o   <= AD_SEL_IDLE;
      rd_n_o  <= STB_IDLE;
      wr_n_o  <= STB_IDLE;
      cs_n_o  <= STB_IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      ad_o    <= ad_d;
      ad_oe_o <= oe_d;
      a_d_o   <= a_d_d;
      rd_n_o  <= STB_IDLE;
      wr_n_o  <= wr_d;
      cs_n_o  <= cs_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

`ifdef RTC_SEQ_ABORT_EN
  always_ff @(posedge clk_i) begin
    if (reset) aborted_o <= 1'b0;
    else       aborted_o <= aborted_d;
  end
`endif

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench: expected bus phases are queued at each start and checked as strobes appear.
`timescale 1ns/1ps
module tb_rtc_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, mode;
  logic [7:0] ad;
  logic       ad_oe, a_d, rd_n, wr_n, cs_n, busy, done;
  logic       s_start;
  logic [7:0] s_ad;
  logic       s_ad_oe, s_a_d, s_rd_n, s_wr_n, s_cs_n, s_busy, s_done;
`ifdef RTC_SEQ_ABORT_EN
  logic       abort, aborted, s_aborted;
`endif

  rtc_bus_sequencer dut (
    .clk_i(clk), .reset(reset), .start_i(start), .mode_24h_i(mode),
    .ad_o(ad), .ad_oe_o(ad_oe), .a_d_o(a_d), .rd_n_o(rd_n), .wr_n_o(wr_n),
    .cs_n_o(cs_n), .busy_o(busy),
`ifdef RTC_SEQ_ABORT_EN
    .abort_i(abort), .aborted_o(aborted),
`endif
    .done_o(done)
  );

  rtc_bus_sequencer #(.DATA_W(8), .N_ENTRIES(4), .T_STROBE(1), .T_GAP(1)) dut_s (
    .clk_i(clk), .reset(reset), .start_i(s_start), .mode_24h_i(1'b1),
    .ad_o(s_ad), .ad_oe_o(s_ad_oe), .a_d_o(s_a_d), .rd_n_o(s_rd_n), .wr_n_o(s_wr_n),
    .cs_n_o(s_cs_n), .busy_o(s_busy),
`ifdef RTC_SEQ_ABORT_EN
    .abort_i(1'b0), .aborted_o(s_aborted),
`endif
    .done_o(s_done)
  );

  typedef struct {
    logic       a_d;
    logic [7:0] ad;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   cyc = 0, done_cnt = 0, done_cyc = -1, low_cnt = 0;
  logic prev_cs = 1'b1;
  bit   mon_on = 1'b0;

  logic [7:0] tbl_addr [16] = '{8'h02, 8'h02, 8'h10, 8'h00, 8'h21, 8'h22, 8'h23, 8'h24,
                                8'h25, 8'h26, 8'h43, 8'h42, 8'h41, 8'hF2, 8'h01, 8'hF1};
  logic [7:0] tbl_data [16] = '{8'h10, 8'h00, 8'hD2, 8'h0A, 8'h00, 8'h00, 8'h03, 8'h26,
                                8'h04, 8'h16, 8'h23, 8'h58, 8'h59, 8'hF2, 8'h00, 8'hF1};

  function automatic logic [7:0] exp_data(input int e, input logic m);
    if (e == 3) return m ? 8'h0A : 8'h1A;
    return tbl_data[e];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 7-cycle strobe + 7-cycle gap per phase, two phases per entry
  task automatic push_seq(input logic m);
    for (int e = 0; e < 16; e++) begin
      q.push_back('{a_d: 1'b0, ad: tbl_addr[e],   cyc: 1 + 28 * e});
      q.push_back('{a_d: 1'b1, ad: exp_data(e, m), cyc: 15 + 28 * e});
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!mon_on) begin
      prev_cs = cs_n;
      return;
    end
    chk("rd_n_high", 32'(rd_n), 32'd1);
    if (prev_cs === 1'b1 && cs_n === 1'b0) begin
      chk("sb_has_entry", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("phase_cycle", 32'(cyc), 32'(e.cyc));
        chk("phase_a_d", 32'(a_d), 32'(e.a_d));
        chk("phase_ad", 32'(ad), 32'(e.ad));
        chk("phase_oe", 32'(ad_oe), 32'd1);
        chk("phase_wr_n", 32'(wr_n), 32'd0);
      end
      low_cnt = 0;
    end
    if (cs_n === 1'b0) low_cnt++;
    if (prev_cs === 1'b0 && cs_n === 1'b1) chk("strobe_len", 32'(low_cnt), 32'd7);
    prev_cs = cs_n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic run_until(input int n);
    while (cyc < n) tick();
  endtask

  // start_i is high across the edge that ends cycle 0; the first observed cycle is 1
  task automatic start_seq(input logic m);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cyc      = 1;
    mon_on   = 1'b1;
    done_cnt = 0;
    done_cyc = -1;
    monitor();
  endtask

  task automatic check_idle_bus(input string tag);
    chk({tag, "_cs_n"}, 32'(cs_n), 32'd1);
    chk({tag, "_wr_n"}, 32'(wr_n), 32'd1);
    chk({tag, "_rd_n"}, 32'(rd_n), 32'd1);
    chk({tag, "_oe"},   32'(ad_oe), 32'd0);
    chk({tag, "_ad"},   32'(ad), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_run_end(input string tag);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd449);
    chk({tag, "_sb_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int ph;
    logic [7:0] s_exp;
    reset   = 1'b1;
    start   = 1'b0;
    mode    = 1'b0;
    s_start = 1'b0;
`ifdef RTC_SEQ_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_bus("reset");
    chk("reset_a_d", 32'(a_d), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_s_busy", 32'(s_busy), 32'd0);
    prev_cs = cs_n;
    repeat (2) tick();

    // 24 h run with start retriggers at 50/200 and mode toggling mid-sequence
    push_seq(1'b1);
    start_seq(1'b1);
    while (cyc < 450) begin
      start = (cyc == 50 || cyc == 200);
      if (cyc == 30) mode = 1'b0;
      if (cyc == 449) chk("busy_in_done", 32'(busy), 32'd1);
      if (cyc == 448) chk("done_low_before", 32'(done), 32'd0);
      tick();
    end
    start = 1'b0;
    check_run_end("run24");
    chk("idle_oe_after", 32'(ad_oe), 32'd0);

    // 12 h run, mode flipped after start
    push_seq(1'b0);
    start_seq(1'b0);
    while (cyc < 450) begin
      if (cyc == 20) mode = 1'b1;
      tick();
    end
    check_run_end("run12");

    // Reset during entry 5 data strobe (cycles 155-161), then restart
    push_seq(1'b1);
    start_seq(1'b1);
    run_until(157);
    chk("pre_reset_phase", 32'({a_d, cs_n}), 32'd2);
    reset  = 1'b1;
    mon_on = 1'b0;
    tick();
    reset = 1'b0;
    check_idle_bus("midreset");
    chk("midreset_done", 32'(done), 32'd0);
    q.delete();
    repeat (3) tick();
    chk("midreset_stays_idle", 32'(busy), 32'd0);
    push_seq(1'b1);
    start_seq(1'b1);
    run_until(450);
    check_run_end("restart");

    // Short configuration: 1-cycle strobe and gap, 4 entries
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 16) begin
        ph = (c - 1) / 2;
        s_exp = (ph % 2 == 0) ? tbl_addr[ph / 2] : exp_data(ph / 2, 1'b1);
        chk("sweep_cs_n", 32'(s_cs_n), 32'((c - 1) % 2));
        chk("sweep_wr_n", 32'(s_wr_n), 32'((c - 1) % 2));
        chk("sweep_ad", 32'(s_ad), 32'(s_exp));
        chk("sweep_a_d", 32'(s_a_d), 32'(ph % 2));
        chk("sweep_oe", 32'(s_ad_oe), 32'd1);
      end
      chk("sweep_rd_n", 32'(s_rd_n), 32'd1);
      chk("sweep_done", 32'(s_done), 32'(c == 17));
      chk("sweep_busy", 32'(s_busy), 32'(c <= 17));
      @(posedge clk);
      #1;
    end

`ifdef RTC_SEQ_ABORT_EN
    push_seq(1'b1);
    start_seq(1'b1);
    run_until(100);
    abort  = 1'b1;
    mon_on = 1'b0;
    tick();
    abort = 1'b0;
    chk("abort_pulse", 32'(aborted), 32'd1);
    check_idle_bus("abort");
    chk("abort_done", 32'(done), 32'd0);
    tick();
    chk("abort_pulse_end", 32'(aborted), 32'd0);
    repeat (40) tick();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    q.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the multiplexed address/data bus.
REQ-002 SHALL have parameter N_ENTRIES, default 16: number of address/data writes per sequence.
REQ-003 SHALL have parameter T_STROBE, default 7, range 1..255: cycles that cs_n_o/wr_n_o stay low per phase.
REQ-004 SHALL have parameter T_GAP, default 7, range 1..255: idle cycles after each strobe.
REQ-005 SHALL have port clk_i, input, 1: clock.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start_i, input, 1: starts a sequence; sampled only in IDLE.
REQ-008 SHALL have port mode_24h_i, input, 1: 1 = 24 h format, 0 = 12 h; sampled with start_i.
REQ-009 SHALL have port ad_o, output, DATA_W: multiplexed address/data value.
REQ-010 SHALL have port ad_oe_o, output, 1: bus drive enable (replaces tri-state).
REQ-011 SHALL have port a_d_o, output, 1: phase select, 0 = address, 1 = data.
REQ-012 SHALL have ports rd_n_o, wr_n_o, cs_n_o, outputs, 1 each: active-low bus strobes.
REQ-013 SHALL have ports busy_o, output, 1 (sequence active) and done_o, output, 1 (one-cycle completion pulse).

Function
REQ-014 SHALL implement states IDLE, ADDR_STB, ADDR_GAP, DATA_STB, DATA_GAP, DONE.
REQ-015 SHALL register every output; no output is a combinational function of an input.
REQ-016 SHALL move IDLE->ADDR_STB on start_i=1, latch mode_24h_i, and clear the entry index to 0.
REQ-017 SHALL, in ADDR_STB, drive ad_o = entry address, a_d_o=0, ad_oe_o=1, cs_n_o=0, wr_n_o=0, rd_n_o=1 for exactly T_STROBE cycles.
REQ-018 SHALL, in ADDR_GAP, drive cs_n_o=1, wr_n_o=1, hold ad_o and ad_oe_o, for exactly T_GAP cycles.
REQ-019 SHALL make DATA_STB/DATA_GAP identical to ADDR_STB/ADDR_GAP except a_d_o=1 and ad_o = entry data.
REQ-020 SHALL, at the end of DATA_GAP, increment the index and go to ADDR_STB; if the index is N_ENTRIES-1, go to DONE instead.
REQ-021 SHALL, in DONE, pulse done_o for one cycle, set ad_oe_o=0 and ad_o=0, and return to IDLE.
REQ-022 SHALL make each entry take 2*(T_STROBE+T_GAP) cycles, and the first strobe visible the cycle after start_i is sampled.
REQ-023 SHALL hold busy_o=1 from the cycle after start_i is sampled through DONE inclusive.
REQ-024 SHALL ignore start_i while not in IDLE; start_i held high re-triggers only after returning to IDLE.
REQ-025 SHALL keep rd_n_o=1 at all times, since all transactions are writes.
REQ-026 SHALL size the phase counter as $clog2(max(T_STROBE,T_GAP)+1) bits and the index as $clog2(N_ENTRIES) bits, with no wrap beyond N_ENTRIES-1.

Reset
REQ-027 SHALL, on reset=1 at any clock edge including mid-sequence, enter IDLE next cycle with ad_o=0, ad_oe_o=0, a_d_o=0, rd_n_o=1, wr_n_o=1, cs_n_o=1, busy_o=0, done_o=0, and the index and counter at 0.
REQ-028 SHALL give reset priority over start_i and abort_i when they are asserted in the same cycle.

Configuration
REQ-029 SHALL, with RTC_SEQ_ABORT_EN defined, add input abort_i (1 bit) and output aborted_o (1 bit).
REQ-030 SHALL, with RTC_SEQ_ABORT_EN defined, treat abort_i=1 in any non-IDLE state as follows: strobes go high and ad_oe_o=0 the next cycle, aborted_o pulses for one cycle, the block returns to IDLE, and done_o stays 0.
REQ-031 SHALL, without RTC_SEQ_ABORT_EN, omit both ports, and every sequence SHALL run to DONE.

Structure
REQ-032 SHALL place the state enum, the entry struct {addr, data}, and the bus idle constants in package rtc_bus_pkg.
REQ-033 SHALL use sub-module rtc_init_table, a combinational index to {addr, data} lookup, with default entries:
- 02/10, 02/00, 10/D2
- 00/(0A if 24 h, else 1A)
- 21/00, 22/00, 23/03, 24/26, 25/04, 26/16
- 43/23, 42/58, 41/59
- F2/F2, 01/00, F1/F1
REQ-034 SHALL make entries beyond index 15 return 00/00 when N_ENTRIES > 16.

Verification
REQ-035 SHALL cover a default-parameter run: start_i pulse at cycle 0 -> first cs_n_o low cycles 1-7 with ad_o=02, a_d_o=0; done_o=1 only at cycle 449; busy_o low at cycle 450.
REQ-036 SHALL cover mode select: mode_24h_i=1 -> entry 3 data phase ad_o=0A; mode_24h_i=0 -> 1A; mode_24h_i toggled mid-sequence -> no effect.
REQ-037 SHALL cover reset mid-sequence: reset during entry 5 DATA_STB -> next cycle all strobes high, ad_oe_o=0, busy_o=0; a new start_i -> restarts at entry 0, address 02.
REQ-038 SHALL cover start while busy: start_i pulsed at cycles 50 and 200 -> no timing change, exactly one done_o.
REQ-039 SHALL cover parameter sweep T_STROBE=1, T_GAP=1, N_ENTRIES=4 -> strobe low for 1 cycle per phase, done_o at cycle 17.
REQ-040 SHALL cover abort with RTC_SEQ_ABORT_EN: abort_i at cycle 100 -> aborted_o=1 at cycle 101, strobes high, done_o never asserted.
